uart_pixel_loader: RTL and testbench



---
 rtl/uart_pixel_loader.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_uart_pixel_loader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pixel_loader.sv
// uart_pixel_loader: receives a SYNC_BYTE-framed NPIX-byte grayscale image over
// UART 8N1, buffers it in block RAM, then streams it to the CNN core as NPIX
// consecutive valid pixels and waits for the core's result strobe.
// Optional build macro RESULT_TX_EN adds a UART transmitter that reports the
// decision as an ASCII digit ('?' above 9); without it uart_tx is tied high.
module uart_pixel_loader #(
  parameter int unsigned CLK_HZ      = 125000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned NPIX        = 784,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 12500000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] pix_data,
  output logic       pix_valid,
  input  logic [3:0] cnn_decision,
  input  logic       cnn_out_valid,
  output logic       uart_tx,
  output logic       busy,
  output logic       frame_err
);

  localparam int unsigned CPB  = CLK_HZ / BAUD;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned SW   = $clog2(NPIX + 2);
  localparam int unsigned BW   = $clog2(CPB + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT_CYC + 1);

  // ---------------------------------------------------------------- UART RX
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t         rx_state_q, rx_state_d;
  logic [BW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_ferr_q, rx_ferr_d;
  logic              rx_s1_q, rx_s2_q, rx_prev_q;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Receiver next state: start re-check at half bit, then mid-bit sampling.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == BW'(HALF - 1)) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BW'(CPB - 1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BW'(CPB - 1)) begin
          rx_cnt_d   = '0;
          rx_valid_d = rx_s2_q;
          rx_ferr_d  = !rx_s2_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver state register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // ---------------------------------------------------------- frame control
  typedef enum logic [1:0] {HUNT, LOAD, STREAM, WAIT_RES} state_t;

  state_t        st_q, st_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [TW-1:0] tmo_q;
  logic          tmo_hit, we, rd_en, abort, result_fire;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data_q;
  logic          rd_v_q;
  logic [7:0]    pix_data_q;
  logic          pix_valid_q, busy_q, frame_err_q;
  logic [7:0]    mem [NPIX];

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC));

  // Frame FSM next state, buffer write/read enables and abort detection.
  always_comb begin
    st_d        = st_q;
    wr_addr_d   = wr_addr_q;
    scnt_d      = scnt_q;
    we          = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    abort       = 1'b0;
    result_fire = 1'b0;
    unique case (st_q)
      HUNT: begin
        if (rx_valid_q && rx_shift_q == SYNC_BYTE) begin
          st_d      = LOAD;
          wr_addr_d = '0;
        end
      end
      LOAD: begin
        if (rx_valid_q) begin
          we = 1'b1;
          if (wr_addr_q == AW'(NPIX - 1)) begin
            st_d   = STREAM;
            scnt_d = '0;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end else if (rx_ferr_q || tmo_hit) begin
          abort     = 1'b1;
          st_d      = HUNT;
          wr_addr_d = '0;
        end
      end
      STREAM: begin
        // Reads run for NPIX cycles; the state is held two more cycles so
        // the RAM and output registers drain before WAIT_RES.
        rd_en   = (scnt_q < SW'(NPIX));
        rd_addr = scnt_q[AW-1:0];
        scnt_d  = scnt_q + 1'b1;
        if (scnt_q == SW'(NPIX + 1)) st_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (cnn_out_valid) begin
          result_fire = 1'b1;
          st_d        = HUNT;
        end else if (tmo_hit) begin
          st_d = HUNT;
        end
      end
      default: st_d = HUNT;
    endcase
  end

  // Image buffer: synchronous write while loading, 1-cycle read latency.
  always_ff @(posedge sys_clk) begin
    if (we) mem[wr_addr_q] <= rx_shift_q;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  // FSM, timeout counter and registered outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= HUNT;
      wr_addr_q   <= '0;
      scnt_q      <= '0;
      tmo_q       <= '0;
      rd_v_q      <= 1'b0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      wr_addr_q <= wr_addr_d;
      scnt_q    <= scnt_d;
      if (rx_valid_q || st_d != st_q) tmo_q <= '0;
      else if (!tmo_hit) tmo_q <= tmo_q + 1'b1;
      rd_v_q      <= rd_en;
      pix_valid_q <= rd_v_q;
      pix_data_q  <= rd_v_q ? rd_data_q : '0;
      busy_q      <= (st_d != HUNT);
      frame_err_q <= abort;
    end
  end

  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

  // ------------------------------------------------------------ result TX
`ifdef RESULT_TX_EN
  logic [7:0]    tx_char;
  logic          tx_q, tx_busy_q;
  logic [8:0]    tx_shift_q;
  logic [BW-1:0] tx_cnt_q;
  logic [3:0]    tx_bits_q;

  // ASCII digit for 0..9, '?' for anything larger.
  always_comb begin
    tx_char = 8'h3F;
    if (cnn_decision <= 4'd9) tx_char = 8'h30 + {4'h0, cnn_decision};
  end

  // 8N1 transmitter; start bit is driven on load, results arriving while busy are dropped.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bits_q  <= '0;
    end else if (!tx_busy_q) begin
      if (result_fire) begin
        tx_q       <= 1'b0;
        tx_busy_q  <= 1'b1;
        tx_shift_q <= {1'b1, tx_char};
        tx_cnt_q   <= '0;
        tx_bits_q  <= 4'd9;
      end
    end else if (tx_cnt_q == BW'(CPB - 1)) begin
      tx_cnt_q <= '0;
      if (tx_bits_q == 4'd0) begin
        tx_busy_q <= 1'b0;
      end else begin
        tx_q       <= tx_shift_q[0];
        tx_shift_q <= {1'b1, tx_shift_q[8:1]};
        tx_bits_q  <= tx_bits_q - 1'b1;
      end
    end else begin
      tx_cnt_q <= tx_cnt_q + 1'b1;
    end
  end

  assign uart_tx = tx_q;
`else
  // Decision and result strobe only feed the result transmitter.
  logic unused_result;
  assign unused_result = ^{cnn_decision, result_fire};
  assign uart_tx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Self-checking bench for uart_pixel_loader with a small frame (NPIX=48),
// 16 clocks per UART bit and a 2000-cycle timeout.
module tb_uart_pixel_loader;

  localparam int unsigned NPIX = 48;
  localparam int unsigned CPB  = 16;
  localparam int unsigned TMO  = 2000;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic [3:0] cnn_decision;
  logic       cnn_out_valid;
  logic       uart_tx;
  logic       busy;
  logic       frame_err;

  uart_pixel_loader #(
    .CLK_HZ(1600), .BAUD(100), .NPIX(NPIX), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .cnn_decision(cnn_decision), .cnn_out_valid(cnn_out_valid),
    .uart_tx(uart_tx), .busy(busy), .frame_err(frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Output monitor, sampled on the falling edge.
  logic [7:0] cap[$];
  int  valid_cycles = 0, runs = 0, ferr_cycles = 0, ferr_pulses = 0, tx_low = 0;
  logic prev_valid = 1'b0, prev_ferr = 1'b0;
  time rise_t = 0;
  time last_stop_t = 0;

  always @(negedge sys_clk) begin
    if (pix_valid === 1'b1) begin
      cap.push_back(pix_data);
      valid_cycles <= valid_cycles + 1;
      if (!prev_valid) begin
        runs   <= runs + 1;
        rise_t <= $time;
      end
    end
    if (frame_err === 1'b1) begin
      ferr_cycles <= ferr_cycles + 1;
      if (!prev_ferr) ferr_pulses <= ferr_pulses + 1;
    end
    if (uart_tx !== 1'b1) tx_low <= tx_low + 1;
    prev_valid <= (pix_valid === 1'b1);
    prev_ferr  <= (frame_err === 1'b1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge sys_clk);
  endtask

  // One 8N1 character, driven from falling edges; bad stop bit on request.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      if (i == 9) last_stop_t = $time;
      cycles(CPB);
    end
    uart_rx = 1'b1;
  endtask

  task automatic capture_tx(output logic [7:0] ch, output bit ok);
    ok = 1'b0;
    ch = '0;
    for (int k = 0; k < 64 && uart_tx === 1'b1; k++) @(negedge sys_clk);
    if (uart_tx !== 1'b0) return;
    cycles(CPB / 2);
    if (uart_tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      cycles(CPB);
      ch[i] = uart_tx;
    end
    cycles(CPB);
    ok = (uart_tx === 1'b1);
  endtask

  typedef struct {
    int unsigned npre;
    bit          rnd;
    bit          give_res;
    logic [3:0]  dec;
    logic [7:0]  exp_char;
  } frame_vec_t;

  typedef struct {
    logic [7:0] b;
    bit         stop_ok;
    bit         exp_busy;
  } hunt_vec_t;

  // Full frame: optional garbage, sync, NPIX pixels; checks the stream
  // against the sent pixels, then delivers a result or lets WAIT_RES time out.
  task automatic run_frame(input frame_vec_t v);
    logic [7:0] garb [3];
    logic [7:0] pix  [NPIX];
    int base_v, base_r, base_f, base_c, lat, k;
    logic [7:0] ch;
    bit ok;
    garb[0] = 8'h00; garb[1] = 8'hFF; garb[2] = 8'h5A;
    for (int i = 0; i < NPIX; i++) pix[i] = v.rnd ? 8'($urandom_range(0, 255)) : 8'(i % 256);
    #1;
    base_v = valid_cycles; base_r = runs; base_f = ferr_pulses; base_c = cap.size();
    @(negedge sys_clk);
    for (int i = 0; i < int'(v.npre); i++) send_byte(garb[i % 3], 1'b1);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < NPIX; i++) send_byte(pix[i], 1'b1);
    #1;
    check("busy_streaming", busy, 1);
    k = 0;
    while (k < int'(NPIX) + 100 && !(valid_cycles - base_v == NPIX && pix_valid === 1'b0)) begin
      @(negedge sys_clk);
      #1;
      k++;
    end
    check("valid_count", valid_cycles - base_v, NPIX);
    check("valid_runs", runs - base_r, 1);
    check("ferr_in_good_frame", ferr_pulses - base_f, 0);
    lat = int'((rise_t - last_stop_t) / 10);
    check("first_valid_latency_window", (lat >= 10 && lat <= 18), 1);
    check("pix_data_idle_zero", pix_data, 0);
    check("busy_wait_res", busy, 1);
    for (int i = 0; i < NPIX; i++)
      check("pixel", (base_c + i < cap.size()) ? {56'd0, cap[base_c + i]} : 64'hDEAD, pix[i]);
    @(negedge sys_clk);
    if (v.give_res) begin
      base_v = tx_low;
      cnn_decision  = v.dec;
      cnn_out_valid = 1'b1;
      @(negedge sys_clk);
      cnn_out_valid = 1'b0;
      cnn_decision  = '0;
      #1;
      check("busy_after_result", busy, 0);
`ifdef RESULT_TX_EN
      capture_tx(ch, ok);
      check("tx_frame_ok", ok, 1);
      check("tx_char", ch, v.exp_char);
`else
      cycles(200);
      #1;
      check("uart_tx_idle", tx_low - base_v, 0);
`endif
    end else begin
      k = 0;
      while (k < int'(TMO) + 200 && busy === 1'b1) begin
        @(negedge sys_clk);
        k++;
      end
      #1;
      check("wait_res_timeout_busy", busy, 0);
      check("wait_res_timeout_late_enough", (k >= int'(TMO) - 20), 1);
      check("wait_res_timeout_no_ferr", ferr_pulses - base_f, 0);
    end
  endtask

  frame_vec_t frames [4];
  hunt_vec_t  hunts  [6];

  initial begin
    int base_v, base_f, base_fc, k;

    frames[0] = '{npre: 0, rnd: 1'b0, give_res: 1'b1, dec: 4'd7,  exp_char: 8'h37};
    frames[1] = '{npre: 3, rnd: 1'b0, give_res: 1'b1, dec: 4'd12, exp_char: 8'h3F};
    frames[2] = '{npre: 0, rnd: 1'b1, give_res: 1'b0, dec: 4'd0,  exp_char: 8'h00};
    frames[3] = '{npre: 0, rnd: 1'b1, give_res: 1'b1, dec: 4'd9,  exp_char: 8'h39};

    hunts[0] = '{b: 8'h00, stop_ok: 1'b1, exp_busy: 1'b0};
    hunts[1] = '{b: 8'hFF, stop_ok: 1'b1, exp_busy: 1'b0};
    hunts[2] = '{b: 8'h5A, stop_ok: 1'b1, exp_busy: 1'b0};
    hunts[3] = '{b: 8'hA5, stop_ok: 1'b0, exp_busy: 1'b0};
    hunts[4] = '{b: 8'hA4, stop_ok: 1'b1, exp_busy: 1'b0};
    hunts[5] = '{b: 8'hA5, stop_ok: 1'b1, exp_busy: 1'b1};

    rst_n = 1'b0; uart_rx = 1'b1; cnn_decision = '0; cnn_out_valid = 1'b0;
    cycles(5);
    #1;
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_uart_tx", uart_tx, 1);
    @(negedge sys_clk);
    rst_n = 1'b1;
    cycles(5);

    // Result strobe while hunting has no effect.
    cnn_decision = 4'd3; cnn_out_valid = 1'b1;
    @(negedge sys_clk);
    cnn_out_valid = 1'b0;
    cycles(3);
    #1;
    check("result_in_hunt_busy", busy, 0);

    // Sync detection in HUNT; a framed-good sync is then aborted by a bad stop bit.
    foreach (hunts[i]) begin
      #1;
      base_f = ferr_pulses;
      @(negedge sys_clk);
      send_byte(hunts[i].b, hunts[i].stop_ok);
      cycles(4);
      #1;
      check("hunt_busy", busy, hunts[i].exp_busy);
      check("hunt_no_ferr", ferr_pulses - base_f, 0);
      if (hunts[i].exp_busy) begin
        @(negedge sys_clk);
        send_byte(8'h12, 1'b0);
        cycles(4);
        #1;
        check("abort_busy", busy, 0);
        check("abort_ferr_pulse", ferr_pulses - base_f, 1);
      end
    end

    // Short low glitch must not be taken as a start bit.
    @(negedge sys_clk);
    uart_rx = 1'b0;
    cycles(3);
    uart_rx = 1'b1;
    cycles(20);
    send_byte(8'hA5, 1'b1);
    cycles(4);
    #1;
    check("glitch_then_sync_busy", busy, 1);
    base_f = ferr_pulses;
    @(negedge sys_clk);
    send_byte(8'h00, 1'b0);
    cycles(4);
    #1;
    check("glitch_abort_ferr", ferr_pulses - base_f, 1);

    foreach (frames[i]) run_frame(frames[i]);

    // Framing error mid-load, then a good frame from address 0.
    #1;
    base_v = valid_cycles; base_f = ferr_pulses; base_fc = ferr_cycles;
    @(negedge sys_clk);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 20; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    send_byte(8'hC3, 1'b0);
    cycles(4);
    #1;
    check("ferr_mid_load_pulse", ferr_pulses - base_f, 1);
    check("ferr_single_cycle", ferr_cycles - base_fc, 1);
    check("ferr_busy", busy, 0);
    check("ferr_no_valid", valid_cycles - base_v, 0);
    run_frame('{npre: 0, rnd: 1'b1, give_res: 1'b1, dec: 4'd3, exp_char: 8'h33});

    // Inter-byte timeout during LOAD.
    #1;
    base_v = valid_cycles; base_f = ferr_pulses;
    @(negedge sys_clk);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 10; i++) send_byte(8'(i), 1'b1);
    k = 0;
    while (k < int'(TMO) + 600 && ferr_pulses == base_f) begin
      @(negedge sys_clk);
      #1;
      k++;
    end
    check("timeout_ferr", ferr_pulses - base_f, 1);
    check("timeout_not_early", (k >= int'(TMO) - 12), 1);
    check("timeout_not_late", (k <= int'(TMO) + 12), 1);
    check("timeout_busy", busy, 0);
    check("timeout_no_valid", valid_cycles - base_v, 0);

    // Asynchronous reset in the middle of streaming.
    @(negedge sys_clk);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < NPIX; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    #1;
    base_v = valid_cycles;
    k = 0;
    while (k < 200 && valid_cycles - base_v < 20) begin
      @(negedge sys_clk);
      #1;
      k++;
    end
    check("reached_pixel_20", (valid_cycles - base_v >= 20), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_pix_valid", pix_valid, 0);
    check("async_rst_pix_data", pix_data, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_uart_tx", uart_tx, 1);
    cycles(3);
    rst_n = 1'b1;
    #1;
    base_v = valid_cycles;
    cycles(200);
    #1;
    check("post_rst_no_valid", valid_cycles - base_v, 0);
    check("post_rst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #(150000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
